// File: rtl/pixel_array.sv
// 2x2 integrating pixel array with single-slope conversion and tri-state column readout.
// Each pixel integrates exposure, then latches its column bus code when its ramp reaches its level.
module pixel_array #(
    parameter int unsigned RATE_00 = 128,
    parameter int unsigned RATE_01 = 128,
    parameter int unsigned RATE_10 = 128,
    parameter int unsigned RATE_11 = 128
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       anaBias1,
    input  logic       anaRamp,
    input  logic       anaReset,
    input  logic       erase,
    input  logic       expose,
    input  logic       read1,
    input  logic       read2,
    inout  wire  [7:0] pixData1,
    inout  wire  [7:0] pixData2
);

    // Pixel index p = row*2 + col, so bit 0 of p selects the column bus.
    localparam logic [3:0][8:0] RATE_S = {9'(RATE_11), 9'(RATE_10), 9'(RATE_01), 9'(RATE_00)};

    logic [3:0][15:0] acc_q,  acc_d;
    logic [3:0][7:0]  ramp_q, ramp_d;
    logic [3:0]       trip_q, trip_d;
    logic [3:0][7:0]  mem_q,  mem_d;
    logic [1:0][7:0]  bus_s;
    logic             drv_row0_s;
    logic             drv_row1_s;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [8:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {8'd0, b};
        if (s[16]) begin
            return 16'hFFFF;
        end else begin
            return s[15:0];
        end
    endfunction

    assign bus_s[0] = pixData1;
    assign bus_s[1] = pixData2;

    // Per-pixel next state: erase beats expose beats conversion.
    always_comb begin
        acc_d  = acc_q;
        ramp_d = ramp_q;
        trip_d = trip_q;
        mem_d  = mem_q;
        for (int p = 0; p < 4; p++) begin
            if (erase) begin
                if (anaReset) begin
                    acc_d[p]  = 16'd0;
                    ramp_d[p] = 8'd0;
                    trip_d[p] = 1'b0;
                end else begin
                    acc_d[p]  = acc_q[p];
                end
            end else if (expose) begin
                if (anaBias1) begin
                    acc_d[p] = sat_add(acc_q[p], RATE_S[p]);
                end else begin
                    acc_d[p] = acc_q[p];
                end
            end else if (anaRamp && !trip_q[p]) begin
                mem_d[p] = bus_s[p[0]];
                // A saturated ramp always trips so a conversion can never stall.
                if ((ramp_q[p] >= acc_q[p][15:8]) || (ramp_q[p] == 8'hFF)) begin
                    trip_d[p] = 1'b1;
                end else begin
                    trip_d[p] = 1'b0;
                end
                if (ramp_q[p] == 8'hFF) begin
                    ramp_d[p] = 8'hFF;
                end else begin
                    ramp_d[p] = ramp_q[p] + 8'd1;
                end
            end else begin
                mem_d[p] = mem_q[p];
            end
        end
    end

    // Pixel state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q  <= '0;
            ramp_q <= '0;
            trip_q <= '0;
            mem_q  <= '0;
        end else begin
            acc_q  <= acc_d;
            ramp_q <= ramp_d;
            trip_q <= trip_d;
            mem_q  <= mem_d;
        end
    end

    // Row 0 wins when both reads are high; reset releases both buses.
    assign drv_row0_s = reset & read1;
    assign drv_row1_s = reset & ~read1 & read2;

    assign pixData1 = drv_row0_s ? mem_q[0] : (drv_row1_s ? mem_q[2] : 8'hzz);
    assign pixData2 = drv_row0_s ? mem_q[1] : (drv_row1_s ? mem_q[3] : 8'hzz);

endmodule

// File: tb/tb_pixel_array.sv
// Bench for pixel_array: two instances (default and mixed rates) checked each cycle against a
// per-pixel arithmetic model, plus literal frame results.
module tb_pixel_array;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, anaBias1, anaRamp, anaReset, erase, expose, read1, read2;
    logic [7:0] code1, code2;
    wire  [7:0] a1, a2, b1, b2;
    logic drv_en;

    // The bench owns the buses whenever the array must not drive them.
    assign drv_en = !(rst_n && (read1 || read2));
    assign a1 = drv_en ? code1 : 8'hzz;
    assign a2 = drv_en ? code2 : 8'hzz;
    assign b1 = drv_en ? code1 : 8'hzz;
    assign b2 = drv_en ? code2 : 8'hzz;

    pixel_array dut_a (
        .clk(clk), .reset(rst_n), .anaBias1(anaBias1), .anaRamp(anaRamp), .anaReset(anaReset),
        .erase(erase), .expose(expose), .read1(read1), .read2(read2),
        .pixData1(a1), .pixData2(a2)
    );

    pixel_array #(.RATE_00(0), .RATE_01(128), .RATE_10(64), .RATE_11(256)) dut_b (
        .clk(clk), .reset(rst_n), .anaBias1(anaBias1), .anaRamp(anaRamp), .anaReset(anaReset),
        .erase(erase), .expose(expose), .read1(read1), .read2(read2),
        .pixData1(b1), .pixData2(b2)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Model: index i = dut*4 + row*2 + col
    int rate [8] = '{128, 128, 128, 128, 0, 128, 64, 256};
    int m_acc [8];
    int m_ramp [8];
    int m_trip [8];
    int m_mem [8];

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) begin
            m_acc[i] = 0; m_ramp[i] = 0; m_trip[i] = 0; m_mem[i] = 0;
        end
    endfunction

    function automatic int bus_exp(int d, int c);
        if (rst_n && read1) return m_mem[d*4 + c];
        else if (rst_n && read2) return m_mem[d*4 + 2 + c];
        else return (c == 0) ? int'(code1) : int'(code2);
    endfunction

    function automatic int act_bus(int d, int c);
        case (d*2 + c)
            0: return int'(a1);
            1: return int'(a2);
            2: return int'(b1);
            default: return int'(b2);
        endcase
    endfunction

    function automatic void model_update();
        int bus [4];
        int i;
        if (!rst_n) return;
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 2; c++)
                bus[d*2 + c] = bus_exp(d, c);
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 4; p++) begin
                i = d*4 + p;
                if (erase) begin
                    if (anaReset) begin
                        m_acc[i] = 0; m_ramp[i] = 0; m_trip[i] = 0;
                    end
                end else if (expose) begin
                    if (anaBias1) m_acc[i] = (m_acc[i] + rate[i] > 65535) ? 65535 : m_acc[i] + rate[i];
                end else if (anaRamp && m_trip[i] == 0) begin
                    m_mem[i] = bus[d*2 + (p % 2)];
                    if (m_ramp[i] >= m_acc[i] / 256 || m_ramp[i] == 255) m_trip[i] = 1;
                    if (m_ramp[i] < 255) m_ramp[i] = m_ramp[i] + 1;
                end
            end
        end
    endfunction

    // Continuous bus comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < 2; c++) begin
                    checks++;
                    if (act_bus(d, c) != bus_exp(d, c)) begin
                        errors++;
                        $display("FAIL bus_dut%0d_col%0d t=%0t got %0d want %0d", d, c, $time,
                                 act_bus(d, c), bus_exp(d, c));
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        erase = 1'b0; expose = 1'b0; anaBias1 = 1'b0; anaRamp = 1'b0; anaReset = 1'b0;
    endtask

    task automatic do_erase(input int n, input logic ar);
        idle(); erase = 1'b1; anaReset = ar;
        for (int i = 0; i < n; i++) tick();
        idle();
    endtask

    task automatic do_expose(input int n);
        idle(); expose = 1'b1; anaBias1 = 1'b1;
        for (int i = 0; i < n; i++) tick();
        idle();
    endtask

    task automatic do_ramp(input int n);
        idle(); anaRamp = 1'b1;
        for (int k = 0; k < n; k++) begin
            code1 = 8'(k); code2 = 8'(k);
            tick();
        end
        idle();
    endtask

    task automatic frame(input bit dead_erase);
        read1 = 1'b0; read2 = 1'b0;
        do_erase(5, 1'b1);
        do_expose(255);
        if (dead_erase) do_erase(5, 1'b0);
        do_ramp(256);
    endtask

    initial begin
        rst_n = 1'b0; read1 = 1'b0; read2 = 1'b0; code1 = 8'd0; code2 = 8'd0;
        idle();
        model_reset();
        cmp_en = 1'b1;

        // Reset: buses released even with read1 high, memories read back 0 afterwards.
        code1 = 8'h5A; read1 = 1'b1; #3;
        chk("reset_bus_release", a1, 8'h5A);
        read1 = 1'b0;
        tick(); tick();
        rst_n = 1'b1; read1 = 1'b1; #1;
        chk("reset_mem_a", a1, 8'd0);
        chk("reset_mem_b", b2, 8'd0);
        read1 = 1'b0;

        // Nominal frame on both instances.
        frame(1'b0);
        read1 = 1'b1; #1;
        chk("frame_a_r0c0", a1, 8'd127);
        chk("frame_a_r0c1", a2, 8'd127);
        chk("rate0_b_r0c0", b1, 8'd0);
        chk("frame_b_r0c1", b2, 8'd127);
        read1 = 1'b0; read2 = 1'b1; #1;
        chk("frame_a_r1c0", a1, 8'd127);
        chk("rate64_b_r1c0", b1, 8'd63);
        chk("rate256_b_r1c1", b2, 8'd255);
        read1 = 1'b1; #1;
        chk("both_reads_a", a1, 8'd127);
        chk("both_reads_b", b1, 8'd0);
        read1 = 1'b0; read2 = 1'b0; code1 = 8'hC3; #1;
        chk("reads_low_release", a1, 8'hC3);

        // Erase without reset supply must not disturb the exposure.
        frame(1'b1);
        read1 = 1'b1; #1;
        chk("dead_erase_a", a1, 8'd127);
        read1 = 1'b0;

        // Reset in the middle of a conversion.
        do_erase(5, 1'b1);
        do_expose(255);
        do_ramp(100);
        anaRamp = 1'b1;
        rst_n = 1'b0; model_reset();
        read1 = 1'b1; code1 = 8'h3C; #1;
        chk("midconv_reset_release", a1, 8'h3C);
        tick(); tick(); tick();
        rst_n = 1'b1; anaRamp = 1'b0; #1;
        chk("midconv_mem_cleared", a1, 8'd0);
        read1 = 1'b0;
        frame(1'b0);
        read1 = 1'b1; #1;
        chk("post_reset_frame", a1, 8'd127);
        read1 = 1'b0;

        // Randomized traffic checked by the model every cycle.
        for (int n = 0; n < 3000; n++) begin
            erase    = ($urandom_range(0, 99) < 5);
            anaReset = ($urandom_range(0, 99) < 70);
            expose   = ($urandom_range(0, 99) < 30);
            anaBias1 = ($urandom_range(0, 99) < 80);
            anaRamp  = ($urandom_range(0, 99) < 60);
            read1    = ($urandom_range(0, 99) < 15);
            read2    = ($urandom_range(0, 99) < 15);
            code1    = 8'($urandom);
            code2    = 8'($urandom);
            if ($urandom_range(0, 999) < 3) begin
                rst_n = 1'b0; model_reset();
            end else begin
                rst_n = 1'b1;
            end
            tick();
        end

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
